clock_sequencer: RTL

//  Next-generation CPU clock source. Replaces the fixed run/manual mux with a 4-mode sequencer.

---
 rtl/clock_pkg.sv | 17 +
 rtl/button_debouncer.sv | 49 ++++
 rtl/clock_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared encodings for the CPU clock sequencer: operating modes and FSM states.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HIGH = 2'b01,
        S_LOW  = 2'b10
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, consecutive-sample debounce counter,
// and a one-cycle pulse on each accepted press (no event on release).
module button_debouncer #(
    parameter int debounce_cycles = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CW = $clog2(debounce_cycles + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // NOTE: every register here uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(debounce_cycles - 1)) begin
                // The last of debounce_cycles consecutive differing samples: accept it.
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;

endmodule

// File: rtl/clock_sequencer.sv
// CPU clock sequencer: RUN / STEP / BURST / HOLD modes producing a 50% duty clk_out and a
// clk_en strobe; phases are never truncated by mode, divisor or halt changes.
module clock_sequencer
    import clock_pkg::*;
#(
    parameter int div_width       = 16,
    parameter int debounce_cycles = 10,
    parameter int burst_width     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [div_width-1:0]   div,
    input  logic                   step_btn,
    input  logic [burst_width-1:0] burst_len,
    input  logic                   hlt,
    output logic                   clk_out,
    output logic                   clk_en,
    output logic                   running,
    output logic                   halted,
    output logic [burst_width-1:0] burst_remaining
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [div_width-1:0]   r_phase;
    logic [div_width-1:0]   r_div_l;
    logic [burst_width-1:0] r_burst_rem;
    logic                   r_halted;
    logic                   r_clk_out;
    logic                   r_clk_en;

    logic                   w_btn_level;
    logic                   w_btn_rise;
    logic                   w_step_req;
    mode_t                  w_mode;
    logic [div_width-1:0]   w_div_eff;
    logic                   w_halt;
    logic                   w_start;
    logic                   w_owed;
    logic                   w_phase_last;
    logic                   w_sample;
    logic                   w_load;
    logic                   w_clk_out_nxt;
    logic                   w_clk_en_nxt;
    logic                   w_running;

    button_debouncer #(
        .debounce_cycles (debounce_cycles)
    ) u_step_btn (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (step_btn),
        .btn_level (w_btn_level),
        .btn_rise  (w_btn_rise)
    );

    assign w_step_req   = w_btn_rise & w_btn_level;
    assign w_mode       = mode_t'(mode);
    assign w_div_eff    = (div == '0) ? div_width'(1) : div;
    // A halt request seen this cycle already blocks any new period.
    assign w_halt       = r_halted | hlt;
    assign w_start      = !w_halt && ((w_mode == MODE_RUN) ||
                                      (w_mode == MODE_STEP && w_step_req) ||
                                      (w_mode == MODE_BURST && w_step_req && burst_len != '0));
    assign w_owed       = !w_halt && ((w_mode == MODE_RUN) ||
                                      (w_mode == MODE_BURST && r_burst_rem != '0));
    assign w_phase_last = (r_phase == r_div_l - div_width'(1));
    assign w_sample     = (r_state == S_IDLE) || (r_state == S_LOW && w_phase_last);
    assign w_load       = w_sample && (w_state_nxt == S_HIGH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start)      w_state_nxt = S_HIGH;
            S_HIGH: if (w_phase_last) w_state_nxt = S_LOW;
            S_LOW:  if (w_phase_last) w_state_nxt = w_owed ? S_HIGH : S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_clk_out_nxt = (w_state_nxt == S_HIGH);
        w_clk_en_nxt  = w_clk_out_nxt && (r_state != S_HIGH);
        w_running     = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= '0;
            r_div_l     <= div_width'(1);
            r_burst_rem <= '0;
            r_halted    <= 1'b0;
            r_clk_out   <= 1'b0;
            r_clk_en    <= 1'b0;
        end else begin
            r_clk_out <= w_clk_out_nxt;
            r_clk_en  <= w_clk_en_nxt;
            r_halted  <= r_halted | hlt;

            if (r_state != S_IDLE && w_state_nxt == r_state) begin
                r_phase <= r_phase + div_width'(1);
            end else begin
                r_phase <= '0;
            end

            if (w_load) begin
                r_div_l <= w_div_eff;
            end

            // Burst count only moves at sample points, so a burst is abandoned cleanly.
            if (w_sample) begin
                if (w_state_nxt != S_HIGH || w_mode != MODE_BURST) begin
                    r_burst_rem <= '0;
                end else if (r_state == S_IDLE) begin
                    r_burst_rem <= burst_len - burst_width'(1);
                end else begin
                    r_burst_rem <= r_burst_rem - burst_width'(1);
                end
            end
        end
    end

    assign clk_out         = r_clk_out;
    assign clk_en          = r_clk_en;
    assign running         = w_running;
    assign halted          = r_halted;
    assign burst_remaining = r_burst_rem;

endmodule
